serial_mod_tx: RTL and testbench
================================

Name: serial_mod_tx

Overview:
Serializer and stimulus source for the serial divisibility-checking stream. It accepts parallel words over a valid/ready handshake and shifts each one out MSB-first on a 1-bit stream with per-bit valid and a last marker. Alongside each bit it reports the running remainder of the transmitted prefix modulo DIVISOR and a divisible flag, which the verification bench uses as the golden model for the serial divisibility checker.

Parameters:
WIDTH, 8, bits per word; must be >= 2.
DIVISOR, 5, modulus for the running remainder; must be >= 2.
RW, $clog2(DIVISOR), width of rem (derived localparam, not overridable).

Ports:
clk  input  1  clock; all state changes on posedge.
resetn  input  1  synchronous, active-low reset.
in_data  input  WIDTH  parallel word to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a word this cycle.
dout  output  1  serial bit, MSB-first.
dout_valid  output  1  dout carries a word bit this cycle.
dout_last  output  1  dout is the LSB (final bit) of the current word.
rem  output  RW  (value of word prefix up to and including dout) mod DIVISOR.
div_flag  output  1  rem==0 and the prefix so far is nonzero.

Behaviour:
- Reset is sampled at posedge clk: resetn=0 forces the IDLE state and sets dout=0, dout_valid=0, dout_last=0, rem=0, div_flag=0, and bit counter=0. in_ready=1 while in IDLE.
- States: IDLE and SHIFT.
  - IDLE: in_ready=1. An accept (in_valid && in_ready) at edge t loads the shift register and enters SHIFT. The MSB appears on dout with dout_valid=1 in the cycle after edge t, giving 1-cycle latency.
  - SHIFT: presents one bit per cycle, WIDTH cycles per word. dout_valid=1 for every bit. dout_last=1 only on bit WIDTH-1 (the LSB).
- in_ready is combinational from state and counter: 1 in IDLE, 1 in SHIFT only while dout_last=1, 0 otherwise.
  - An accept during the last bit starts the next word's MSB on the very next cycle. Back-to-back words have no idle gap.
  - Without an accept during the last bit, the block returns to IDLE and drives dout_valid=0, dout_last=0, dout=0.
- Remainder arithmetic: on the first bit of each word, rem = b mod DIVISOR. On each later bit, rem = (2*rem_prev + b) mod DIVISOR.
  - Compute in RW+1 bits with a single conditional subtract of DIVISOR. This is valid because 2*rem+b <= 2*DIVISOR-1.
  - rem, div_flag and dout are registered together and always refer to the same bit.
- nonzero_seen: set on any 1 bit within the word; cleared at each word start, where it takes the first bit's value. div_flag = (rem==0) && nonzero_seen, both evaluated including the current bit.
- Word boundary: rem and nonzero_seen restart at every word's MSB. No state carries across words, including in back-to-back operation.
- In IDLE, rem and div_flag hold 0.
- in_data is sampled only on accept. Changes to in_data at any other time have no effect.
- in_valid may drop at any time without affecting a word already in progress.
- Reset mid-word aborts the word. The first bit after reset release comes only from a new accept.
- The block has no output backpressure. The downstream consumer must accept one bit per cycle while dout_valid=1.

Test Plan:
1. WIDTH=8, DIVISOR=5, send 0x05 -> dout 0,0,0,0,0,1,0,1; rem 0,0,0,0,0,1,2,0; div_flag only on bit 8 together with dout_last; dout_valid high for exactly 8 cycles starting 1 cycle after accept.
2. Send 0xFF -> rem 1,3,2,0,1,3,2,0; div_flag=1 on bits 4 and 8 only.
3. Hold in_valid high with 0x0A then 0x03 -> 16 consecutive dout_valid cycles. 0x0A rem 0,0,0,0,1,2,0,0 with div_flag on bits 7 and 8. 0x03 restarts with rem 0,0,0,0,0,0,1,3 and no div_flag. dout_last on cycles 8 and 16. in_ready high only on those cycles.
4. Send 0x00 -> rem=0 on every bit and div_flag=0 throughout (nonzero_seen never set).
5. Assert resetn=0 for one cycle after 3 bits of 0xA5 -> next cycle all outputs 0 and in_ready=1. A following 0x05 produces exactly the sequence of test 1.
6. Parameter variant WIDTH=4, DIVISOR=3, send 0x9 -> dout 1,0,0,1; rem 1,2,1,0; div_flag on bit 4 only. Toggling in_data mid-word has no effect on dout.

Source files
------------

// File: rtl/serial_mod_tx_if.sv
// Parallel-in handshake and serial-out stream of the divisibility stimulus source.
// The DUT uses the slave modport; the word producer and stream consumer use master.
interface serial_mod_tx_if #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 5
);
    localparam int RW = $clog2(DIVISOR);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;
    logic [RW-1:0]    rem;
    logic             div_flag;

    modport master (
        output in_data, in_valid,
        input  in_ready, dout, dout_valid, dout_last, rem, div_flag
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dout, dout_valid, dout_last, rem, div_flag
    );
endinterface

// File: rtl/serial_mod_tx.sv
// MSB-first serializer that also emits the running remainder of the sent prefix
// modulo DIVISOR, used as the golden reference for the serial divisibility checker.
module serial_mod_tx #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 5
) (
    input  logic              clk,
    input  logic              resetn,
    serial_mod_tx_if.slave    bus
);
    localparam int RW = $clog2(DIVISOR);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             dout_reg, dout_next;
    logic             valid_reg, valid_next;
    logic             last_reg, last_next;
    logic [RW-1:0]    rem_reg, rem_next;
    logic             nz_reg, nz_next;
    logic             div_reg, div_next;

    logic             in_ready_c;
    logic             accept;
    logic [RW:0]      sum;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            dout_reg  <= 1'b0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            rem_reg   <= '0;
            nz_reg    <= 1'b0;
            div_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            rem_reg   <= rem_next;
            nz_reg    <= nz_next;
            div_reg   <= div_next;
        end
    end

    always_comb begin
        accept     = bus.in_valid && in_ready_c;
        // {rem, b} is 2*rem+b, at most 2*DIVISOR-1, so one subtract reduces it
        sum        = {rem_reg, shift_reg[WIDTH-1]};
        state_next = IDLE;
        cnt_next   = '0;
        shift_next = shift_reg;
        dout_next  = 1'b0;
        valid_next = 1'b0;
        last_next  = 1'b0;
        rem_next   = '0;
        nz_next    = 1'b0;
        if (accept) begin
            state_next = SHIFT;
            shift_next = {bus.in_data[WIDTH-2:0], 1'b0};
            dout_next  = bus.in_data[WIDTH-1];
            valid_next = 1'b1;
            rem_next   = RW'(bus.in_data[WIDTH-1]);
            nz_next    = bus.in_data[WIDTH-1];
        end else if (state_reg == SHIFT && cnt_reg != CW'(WIDTH-1)) begin
            state_next = SHIFT;
            cnt_next   = cnt_reg + 1'b1;
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            dout_next  = shift_reg[WIDTH-1];
            valid_next = 1'b1;
            last_next  = (cnt_reg == CW'(WIDTH-2));
            if (sum >= (RW+1)'(DIVISOR))
                rem_next = RW'(sum - (RW+1)'(DIVISOR));
            else
                rem_next = RW'(sum);
            nz_next    = nz_reg | shift_reg[WIDTH-1];
        end
        div_next = (rem_next == '0) && nz_next;
    end

    always_comb begin
        in_ready_c     = (state_reg == IDLE) || (cnt_reg == CW'(WIDTH-1));
        bus.in_ready   = in_ready_c;
        bus.dout       = dout_reg;
        bus.dout_valid = valid_reg;
        bus.dout_last  = last_reg;
        bus.rem        = rem_reg;
        bus.div_flag   = div_reg;
    end
endmodule

// File: tb/tb_serial_mod_tx.sv
// Directed bench: stimulus pushes hand-computed per-bit expectations into queues,
// negedge monitors pop and compare whenever dout_valid is high.
module tb_serial_mod_tx;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    serial_mod_tx_if #(.WIDTH(8), .DIVISOR(5)) b8 ();
    serial_mod_tx_if #(.WIDTH(4), .DIVISOR(3)) b4 ();

    serial_mod_tx #(.WIDTH(8), .DIVISOR(5)) dut8 (.clk(clk), .resetn(resetn), .bus(b8));
    serial_mod_tx #(.WIDTH(4), .DIVISOR(3)) dut4 (.clk(clk), .resetn(resetn), .bus(b4));

    typedef struct packed {
        logic       d;
        logic       l;
        logic [2:0] r;
        logic       f;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   passed = 0;
    int   total  = 0;
    int   run8 = 0, last_run8 = 0;
    int   run4 = 0, last_run4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // rems: one nibble per bit, first bit in the top nibble; divs: one bit per bit, MSB first
    task automatic push_exp(input int sel, input logic [7:0] w, input int wd, input int cnt,
                            input logic [31:0] rems, input logic [7:0] divs);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.d = w[wd-1-i];
            e.l = (i == wd-1);
            e.r = rems[28-4*i +: 3];
            e.f = divs[7-i];
            if (sel == 0) q8.push_back(e);
            else          q4.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b8.dout_valid === 1'b1) begin
            run8++;
            if (q8.size() == 0) begin
                total++;
                $display("FAIL w8_unexpected_bit: got dout_valid=1 expected no bit");
            end else begin
                e = q8.pop_front();
                chk("w8_dout", 32'(b8.dout), 32'(e.d));
                chk("w8_last", 32'(b8.dout_last), 32'(e.l));
                chk("w8_rem", 32'(b8.rem), 32'(e.r));
                chk("w8_div", 32'(b8.div_flag), 32'(e.f));
                $display("w8 bit: dout=%0d last=%0d rem=%0d div=%0d", b8.dout, b8.dout_last, b8.rem, b8.div_flag);
            end
        end else begin
            if (run8 > 0) last_run8 = run8;
            run8 = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b4.dout_valid === 1'b1) begin
            run4++;
            if (q4.size() == 0) begin
                total++;
                $display("FAIL w4_unexpected_bit: got dout_valid=1 expected no bit");
            end else begin
                e = q4.pop_front();
                chk("w4_dout", 32'(b4.dout), 32'(e.d));
                chk("w4_last", 32'(b4.dout_last), 32'(e.l));
                chk("w4_rem", 32'(b4.rem), 32'(e.r));
                chk("w4_div", 32'(b4.div_flag), 32'(e.f));
                $display("w4 bit: dout=%0d last=%0d rem=%0d div=%0d", b4.dout, b4.dout_last, b4.rem, b4.div_flag);
            end
        end else begin
            if (run4 > 0) last_run4 = run4;
            run4 = 0;
        end
    end

    task automatic send8(input logic [7:0] w, input logic [31:0] rems, input logic [7:0] divs);
        push_exp(0, w, 8, 8, rems, divs);
        b8.in_data  = w;
        b8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.in_data  = ~w;
        chk("w8_latency", 32'(b8.dout_valid), 32'd1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic idle_check8(input int exp_run);
        @(negedge clk);
        #1;
        chk("w8_idle_valid", 32'(b8.dout_valid), 32'd0);
        chk("w8_idle_ready", 32'(b8.in_ready), 32'd1);
        chk("w8_idle_rem", 32'(b8.rem), 32'd0);
        chk("w8_idle_div", 32'(b8.div_flag), 32'd0);
        chk("w8_run_length", 32'(last_run8), 32'(exp_run));
        chk("w8_queue_drained", 32'(q8.size()), 32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        b8.in_valid = 1'b0;
        b8.in_data  = '0;
        b4.in_valid = 1'b0;
        b4.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(b8.dout_valid), 32'd0);
        chk("reset_dout", 32'(b8.dout), 32'd0);
        chk("reset_last", 32'(b8.dout_last), 32'd0);
        chk("reset_rem", 32'(b8.rem), 32'd0);
        chk("reset_div", 32'(b8.div_flag), 32'd0);
        chk("reset_ready", 32'(b8.in_ready), 32'd1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // single words
        send8(8'h05, 32'h0000_0120, 8'h01);
        idle_check8(8);
        send8(8'hFF, 32'h1320_1320, 8'h11);
        idle_check8(8);

        // back-to-back 0x0A then 0x03 with in_valid held high
        push_exp(0, 8'h0A, 8, 8, 32'h0000_1200, 8'h03);
        b8.in_data  = 8'h0A;
        b8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        push_exp(0, 8'h03, 8, 8, 32'h0000_0013, 8'h00);
        b8.in_data = 8'h03;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready_w1", 32'(b8.in_ready), 32'(i == 7));
            @(posedge clk);
            #1;
        end
        b8.in_valid = 1'b0;
        b8.in_data  = 8'hC6;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready_w2", 32'(b8.in_ready), 32'(i == 7));
            @(posedge clk);
            #1;
        end
        idle_check8(16);

        // all-zero word never raises div_flag
        send8(8'h00, 32'h0000_0000, 8'h00);
        idle_check8(8);

        // reset after three bits of 0xA5
        push_exp(0, 8'hA5, 8, 3, 32'h1200_0000, 8'h20);
        b8.in_data  = 8'hA5;
        b8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("midreset_valid", 32'(b8.dout_valid), 32'd0);
        chk("midreset_dout", 32'(b8.dout), 32'd0);
        chk("midreset_last", 32'(b8.dout_last), 32'd0);
        chk("midreset_rem", 32'(b8.rem), 32'd0);
        chk("midreset_div", 32'(b8.div_flag), 32'd0);
        chk("midreset_ready", 32'(b8.in_ready), 32'd1);
        idle_check8(3);
        send8(8'h05, 32'h0000_0120, 8'h01);
        idle_check8(8);

        // 4-bit / mod-3 variant; in_data scrambled while the word shifts out
        push_exp(1, 8'h09, 4, 4, 32'h1210_0000, 8'h10);
        b4.in_data  = 4'h9;
        b4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
        chk("w4_latency", 32'(b4.dout_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            b4.in_data = 4'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        chk("w4_idle_valid", 32'(b4.dout_valid), 32'd0);
        chk("w4_idle_ready", 32'(b4.in_ready), 32'd1);
        chk("w4_run_length", 32'(last_run4), 32'd4);
        chk("w4_queue_drained", 32'(q4.size()), 32'd0);
        chk("w8_quiet", 32'(q8.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
